// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start/data/parity/stop deserializer with error pulses.
// Optional RX_MAJORITY_VOTE_EN: each bit decision is a 2-of-3 vote over the last three ticks.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       ov_baud_tick_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_i,
  input  logic [1:0] parity_mode_i,
  input  logic       rx_fifo_full_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       frame_error_o,
  output logic       parity_error_o,
  output logic       overrun_error_o,
  output logic       rx_idle_o
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] TICK_END  = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx, rx_prev, rx_fall;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev <= rx;
    end

  assign rx      = sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev & ~rx;

  logic bit_val;
`ifdef RX_MAJORITY_VOTE_EN
  // hist_q[0] holds the sample from the previous tick, hist_q[1] the one before it.
  logic [1:0] hist_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)               hist_q <= 2'b11;
    else if (ov_baud_tick_i) hist_q <= {hist_q[0], rx};
  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
`else
  assign bit_val = rx;
`endif

  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    data_sr;
  logic [1:0]    cfg_width, cfg_stop, cfg_parity;
  logic          stop_ext, ferr_f, perr_f;

  logic       at_half, at_end, at_wait, frame_start, cnt_clr;
  logic [2:0] last_bit;

  assign at_half  = ov_baud_tick_i && (tick_cnt == TICK_HALF);
  assign at_end   = ov_baud_tick_i && (tick_cnt == TICK_END);
  // 1.5 SB waits half a bit after the first stop sample, 2 SB a whole bit.
  assign at_wait  = ov_baud_tick_i && (tick_cnt == (cfg_stop[1] ? TICK_END : TICK_HALF));
  assign last_bit = 3'd4 + {1'b0, cfg_width};

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= RX_IDLE;
    else       state <= state_d;

  always_comb begin
    state_d     = state;
    frame_start = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state)
      RX_IDLE:
        if (rx_fall) begin
          state_d     = RX_START;
          frame_start = 1'b1;
        end
      RX_START:
        if (at_half) begin
          if (!bit_val) begin
            state_d = RX_DATA;
            cnt_clr = 1'b1;
          end else begin
            state_d = RX_IDLE;
          end
        end
      RX_DATA:
        if (at_end && bit_cnt == last_bit)
          state_d = cfg_parity[0] ? RX_PARITY : RX_STOP;
      RX_PARITY:
        if (at_end) state_d = RX_STOP;
      RX_STOP:
        if (!stop_ext && at_end && !cfg_stop[0]) state_d = RX_DONE;
        else if (stop_ext && at_wait)            state_d = RX_DONE;
      RX_DONE:
        // a start edge landing in this cycle would otherwise be lost
        if (rx_fall) begin
          state_d     = RX_START;
          frame_start = 1'b1;
        end else begin
          state_d = RX_IDLE;
        end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      data_sr    <= '0;
      cfg_width  <= '0;
      cfg_stop   <= '0;
      cfg_parity <= '0;
      stop_ext   <= 1'b0;
      ferr_f     <= 1'b0;
      perr_f     <= 1'b0;
    end else if (frame_start) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      data_sr    <= '0;
      cfg_width  <= data_width_i;
      cfg_stop   <= stop_bits_i;
      cfg_parity <= parity_mode_i;
      stop_ext   <= 1'b0;
      ferr_f     <= 1'b0;
      perr_f     <= 1'b0;
    end else begin
      if (ov_baud_tick_i) tick_cnt <= cnt_clr ? '0 : tick_cnt + CW'(1);
      if (at_end) begin
        if (state == RX_DATA) begin
          data_sr[bit_cnt] <= bit_val;
          bit_cnt          <= bit_cnt + 3'd1;
        end
        // unused data_sr MSBs are zero, so a full-word XOR is the data parity
        if (state == RX_PARITY) perr_f <= ^data_sr ^ bit_val ^ cfg_parity[1];
        if (state == RX_STOP && !stop_ext) begin
          ferr_f   <= ~bit_val;
          stop_ext <= 1'b1;
        end
      end
    end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rx_data_o       <= '0;
      rx_done_o       <= 1'b0;
      frame_error_o   <= 1'b0;
      parity_error_o  <= 1'b0;
      overrun_error_o <= 1'b0;
    end else begin
      rx_done_o       <= 1'b0;
      frame_error_o   <= 1'b0;
      parity_error_o  <= 1'b0;
      overrun_error_o <= 1'b0;
      if (state == RX_DONE) begin
        frame_error_o  <= ferr_f;
        parity_error_o <= perr_f;
        if (rx_fifo_full_i) begin
          overrun_error_o <= 1'b1;
        end else begin
          rx_done_o <= 1'b1;
          rx_data_o <= data_sr;
        end
      end
    end

  assign rx_idle_o = (state == RX_IDLE);

endmodule
